// File: rtl/axi_dma_wr_responder.sv
`timescale 1ns/1ps
// AXI3-style write responder for the ADC DMA destination port.
// Accepts 64-bit write bursts into on-chip RAM, returns BRESP, and offers a
// registered readback port plus burst / error counters.
module axi_dma_wr_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
  input  logic          axi_aclk,
  input  logic          axi_areset,
  input  logic [31:0]   s_axi_awaddr,
  input  logic [3:0]    s_axi_awlen,
  input  logic [2:0]    s_axi_awsize,
  input  logic [1:0]    s_axi_awburst,
  input  logic [2:0]    s_axi_awprot,
  input  logic [3:0]    s_axi_awcache,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [63:0]   s_axi_wdata,
  input  logic [7:0]    s_axi_wstrb,
  input  logic          s_axi_wlast,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  output logic [1:0]    s_axi_bresp,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data,
  output logic [31:0]   burst_cnt,
  output logic [15:0]   err_cnt
);

  localparam logic [31:0] MEM_WORDS_W = MEM_WORDS[31:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic        fixed_q, fixed_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [63:0] rd_data_q;
  logic [63:0] ram_q [MEM_WORDS];

  logic [31:0]   offset_s;
  logic [31:0]   idx_full_s;
  logic [AW-1:0] wr_idx_s;
  logic          in_range_s;
  logic          at_len_s;
  logic          ends_s;
  logic          mismatch_s;
  logic          err_beat_s;
  logic          we_s;
  logic          unused_s;

  // Addresses below BASE_ADDR wrap to huge offsets and therefore fall out of range.
  assign offset_s   = s_axi_awaddr_lat(addr_q);
  assign idx_full_s = {3'b000, offset_s[31:3]};
  assign wr_idx_s   = offset_s[AW+2:3];
  assign in_range_s = (idx_full_s < MEM_WORDS_W);
  assign at_len_s   = (beat_cnt_q == len_q);
  assign ends_s     = s_axi_wlast | at_len_s;
  assign mismatch_s = s_axi_wlast ^ at_len_s;
  assign err_beat_s = err_q | ~in_range_s | mismatch_s;
  assign unused_s   = ^{s_axi_awprot, s_axi_awcache, offset_s[2:0]};

  function automatic logic [31:0] s_axi_awaddr_lat(input logic [31:0] a);
    return a - BASE_ADDR;
  endfunction

  // Next-state, handshake and counter logic for the IDLE/DATA/RESP sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    fixed_d     = fixed_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    burst_cnt_d = burst_cnt_q;
    err_cnt_d   = err_cnt_q;
    we_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          addr_d     = s_axi_awaddr;
          len_d      = s_axi_awlen;
          fixed_d    = (s_axi_awburst == 2'b00);
          beat_cnt_d = 4'd0;
          err_d      = (s_axi_awsize != 3'd3) || s_axi_awburst[1];
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          state_d    = ST_DATA;
        end else begin
          awready_d  = 1'b1;
        end
      end
      ST_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          // A mismatched ending beat is still written; only earlier errors or range drop it.
          if (!err_q && in_range_s) begin
            we_s = 1'b1;
          end else begin
            we_s = 1'b0;
          end
          err_d = err_beat_s;
          if (ends_s) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = {err_beat_s, 1'b0};
            state_d  = ST_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            if (fixed_q) begin
              addr_d = addr_q;
            end else begin
              addr_d = addr_q + 32'd8;
            end
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          bvalid_d    = 1'b0;
          awready_d   = 1'b1;
          burst_cnt_d = burst_cnt_q + 32'd1;
          if (err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      len_q       <= 4'd0;
      fixed_q     <= 1'b0;
      beat_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      burst_cnt_q <= 32'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      fixed_q     <= fixed_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      burst_cnt_q <= burst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Byte-masked RAM write; contents survive reset but a beat coinciding with reset is dropped.
  always_ff @(posedge axi_aclk) begin
    if (we_s && !axi_areset) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) begin
          ram_q[wr_idx_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered readback; a same-cycle write to the same word returns the old data.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rd_data_q <= 64'd0;
    end else begin
      rd_data_q <= ram_q[rd_addr];
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign rd_data       = rd_data_q;
  assign burst_cnt     = burst_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axi_dma_wr_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for axi_dma_wr_responder: expected B responses and readback
// words are queued by the stimulus and checked by a negedge monitor.
module tb_axi_dma_wr_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned MW   = 64;

  logic        clk;
  logic        axi_areset;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] burst_cnt;
  logic [15:0] err_cnt;

  axi_dma_wr_responder #(.BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awprot(3'b000), .s_axi_awcache(4'b0000),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .rd_addr(rd_addr), .rd_data(rd_data), .burst_cnt(burst_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [1:0]  exp_b_q [$];
  logic [63:0] exp_rd_q [$];
  logic        rd_issue = 1'b0;
  logic        rd_stage = 1'b0;
  logic [63:0] bd [16];
  logic [7:0]  bs [16];
  logic [31:0] exp_burst = 32'd0;
  logic [15:0] exp_err   = 16'd0;
  logic [63:0] val_a, val_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout/empty expected event", name);
  endtask

  // Monitor: checks queued readback data and every B handshake.
  always @(negedge clk) begin
    if (rd_stage) begin
      if (exp_rd_q.size() == 0) fail_now("rd_queue");
      else chk("rd_data", rd_data, exp_rd_q.pop_front());
    end
    rd_stage <= rd_issue;
    if (!axi_areset && bvalid && bready) begin
      if (exp_b_q.size() == 0) fail_now("b_unexpected");
      else chk("bresp", {62'd0, bresp}, {62'd0, exp_b_q.pop_front()});
    end
  end

  task automatic readchk(input int idx, input logic [63:0] exp);
    @(posedge clk); #1;
    rd_addr  = idx[5:0];
    rd_issue = 1'b1;
    exp_rd_q.push_back(exp);
    @(posedge clk); #1;
    rd_issue = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                         input logic [1:0] bt, output bit ok);
    int n;
    @(posedge clk); #1;
    awaddr = a; awlen = l; awsize = s; awburst = bt; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    ok = awready;
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_beat(input int i, input bit last, output bit ok);
    int n;
    wvalid = 1'b1; wdata = bd[i]; wstrb = bs[i]; wlast = last;
    n = 0;
    @(negedge clk);
    while (!wready && n < 50) begin @(negedge clk); n++; end
    ok = wready;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                       input logic [1:0] bt, input int nbeats, input int wlast_at,
                       input logic [1:0] exp_resp);
    bit ok;
    exp_b_q.push_back(exp_resp);
    send_aw(a, l, s, bt, ok);
    if (!ok) begin fail_now("aw_timeout"); return; end
    for (int i = 0; i < nbeats; i++) begin
      send_beat(i, (i == wlast_at), ok);
      if (!ok) begin fail_now("w_timeout"); return; end
    end
    chk("bvalid_after_last", {63'd0, bvalid}, 64'd1);
    chk("wready_after_last", {63'd0, wready}, 64'd0);
    if (bready) begin
      @(posedge clk); #1;
      chk("bvalid_cleared", {63'd0, bvalid}, 64'd0);
      chk("awready_after_b", {63'd0, awready}, 64'd1);
      exp_burst = exp_burst + 32'd1;
      if (exp_resp[1]) exp_err = exp_err + 16'd1;
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_burst_cnt"}, {32'd0, burst_cnt}, {32'd0, exp_burst});
    chk({tag, "_err_cnt"}, {48'd0, err_cnt}, {48'd0, exp_err});
  endtask

  initial begin
    bit ok;
    axi_areset = 1'b1; awaddr = 32'd0; awlen = 4'd0; awsize = 3'd0; awburst = 2'd0;
    awvalid = 1'b0; wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1; rd_addr = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk_counters("rst");
    axi_areset = 1'b0;
    @(posedge clk); #1;
    chk("awready_after_release", {63'd0, awready}, 64'd1);

    // Prefill words 0..3 with known data.
    for (int i = 0; i < 4; i++) begin bd[i] = 64'hA0A0_0000_0000_0000 + 64'(i); bs[i] = 8'hFF; end
    burst(BASE, 4'd3, 3'd3, 2'd1, 4, 3, 2'b00);

    // INCR burst to words 8..11.
    bd[0] = 64'h1111_1111_1111_1111; bd[1] = 64'h2222_2222_2222_2222;
    bd[2] = 64'h3333_3333_3333_3333; bd[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) bs[i] = 8'hFF;
    burst(BASE + 32'h40, 4'd3, 3'd3, 2'd1, 4, 3, 2'b00);
    chk_counters("incr");
    readchk(8, 64'h1111_1111_1111_1111);
    readchk(11, 64'h4444_4444_4444_4444);

    // FIXED burst to word 1 with partial strobe on the second beat.
    val_a = 64'hAAAA_BBBB_CCCC_DDDD; val_b = 64'h1234_5678_9ABC_DEF0;
    bd[0] = val_a; bs[0] = 8'hFF; bd[1] = val_b; bs[1] = 8'h0F;
    burst(BASE + 32'h8, 4'd1, 3'd3, 2'd0, 2, 1, 2'b00);
    readchk(1, {val_a[63:32], val_b[31:0]});

    // Illegal size, out-of-range address, illegal burst type: nothing written.
    bd[0] = 64'hDEAD_BEEF_DEAD_BEEF; bs[0] = 8'hFF; bd[1] = 64'hFEED_FACE_FEED_FACE; bs[1] = 8'hFF;
    burst(BASE + 32'h10, 4'd0, 3'd2, 2'd1, 1, 0, 2'b10);
    chk_counters("size_err");
    burst(BASE + 32'(8 * MW), 4'd1, 3'd3, 2'd1, 2, 1, 2'b10);
    burst(BASE + 32'h18, 4'd0, 3'd3, 2'd2, 1, 0, 2'b10);
    readchk(2, 64'hA0A0_0000_0000_0002);
    readchk(0, 64'hA0A0_0000_0000_0000);
    readchk(3, 64'hA0A0_0000_0000_0003);

    // Early wlast: two beats written, SLVERR.
    bd[0] = 64'h5555_0000_0000_0020; bd[1] = 64'h5555_0000_0000_0021;
    burst(BASE + 32'hA0, 4'd3, 3'd3, 2'd1, 2, 1, 2'b10);
    readchk(20, 64'h5555_0000_0000_0020);
    readchk(21, 64'h5555_0000_0000_0021);
    // Length reached without wlast: both beats written, SLVERR.
    bd[0] = 64'h6666_0000_0000_0024; bd[1] = 64'h6666_0000_0000_0025;
    burst(BASE + 32'hC0, 4'd1, 3'd3, 2'd1, 2, -1, 2'b10);
    readchk(25, 64'h6666_0000_0000_0025);
    chk_counters("mismatch");

    // Back-pressured response stays stable and blocks AW.
    bready = 1'b0;
    burst(BASE + 32'hF0, 4'd0, 3'd3, 2'd3, 1, 0, 2'b10);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_bvalid", {63'd0, bvalid}, 64'd1);
      chk("hold_bresp", {62'd0, bresp}, 64'd2);
      chk("hold_awready", {63'd0, awready}, 64'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_bready", {63'd0, awready}, 64'd1);
    exp_burst = exp_burst + 32'd1;
    exp_err   = exp_err + 16'd1;
    chk_counters("backpressure");

    // Reset after 2 of 8 beats aborts the burst without a response.
    bd[0] = 64'h7777_0000_0000_0040; bd[1] = 64'h7777_0000_0000_0041;
    send_aw(BASE + 32'h140, 4'd7, 3'd3, 2'd1, ok);
    if (!ok) fail_now("aw_timeout_rst");
    send_beat(0, 1'b0, ok);
    send_beat(1, 1'b0, ok);
    axi_areset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wready", {63'd0, wready}, 64'd0);
    chk("midrst_awready", {63'd0, awready}, 64'd0);
    chk("midrst_bvalid", {63'd0, bvalid}, 64'd0);
    exp_burst = 32'd0; exp_err = 16'd0;
    chk_counters("midrst");
    axi_areset = 1'b0;
    @(posedge clk); #1;
    chk("awready_after_midrst", {63'd0, awready}, 64'd1);
    bd[0] = 64'h8888_0000_0000_0050; bd[1] = 64'h8888_0000_0000_0051;
    burst(BASE + 32'h190, 4'd1, 3'd3, 2'd1, 2, 1, 2'b00);
    chk_counters("after_rst");
    readchk(40, 64'h7777_0000_0000_0040);
    readchk(51, 64'h8888_0000_0000_0051);

    chk("b_queue_empty", 64'(exp_b_q.size()), 64'd0);
    chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
